// File: rtl/token_pool_arb_if.sv
// rtl/token_pool_arb_if.sv - request/release/grant bundle between clients and token_pool_arb
interface token_pool_arb_if #(
  parameter int NREQ = 4,
  parameter int WID  = 4
);
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] rel_i;
  logic            drain_i;
  logic [NREQ-1:0] gnt_o;
  logic [WID-1:0]  free_o;
  logic            full_o;
  logic            empty_o;
  logic            idle_o;
  logic            err_o;

  modport master (
    output req_i, rel_i, drain_i,
    input  gnt_o, free_o, full_o, empty_o, idle_o, err_o
  );

  modport slave (
    input  req_i, rel_i, drain_i,
    output gnt_o, free_o, full_o, empty_o, idle_o, err_o
  );
endinterface

// File: rtl/token_pool_arb.sv
// rtl/token_pool_arb.sv - token pool arbiter with drain FSM; TOKEN_RR_EN selects round-robin over fixed priority
module token_pool_arb #(
  parameter int NREQ = 4,
  parameter int WID  = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  token_pool_arb_if.slave  bus
);
  localparam logic [WID-1:0] MAX     = {WID{1'b1}};
  localparam logic [1:0]     S_RUN   = 2'd0;
  localparam logic [1:0]     S_DRAIN = 2'd1;
  localparam logic [1:0]     S_DONE  = 2'd2;

  logic [WID-1:0]  r_free;
  logic [WID-1:0]  r_own [NREQ];
  logic [NREQ-1:0] r_gnt;
  logic [1:0]      r_state;
  logic            r_err;

  logic [NREQ-1:0] w_rel_ok;
  logic [NREQ-1:0] w_pick;
  logic            w_found;
  logic            w_grant;
  logic            w_bad_rel;
  logic [WID-1:0]  w_nrel;
  logic [WID-1:0]  w_free_n;
  logic [1:0]      w_state_n;

  always_comb begin
    w_rel_ok  = '0;
    w_bad_rel = 1'b0;
    w_nrel    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.rel_i[k]) begin
        if (r_own[k] != '0) begin
          w_rel_ok[k] = 1'b1;
          w_nrel      = w_nrel + WID'(1);
        end else begin
          w_bad_rel = 1'b1;
        end
      end
    end
  end

`ifdef TOKEN_RR_EN
  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [RRW-1:0] r_rr;
  logic [RRW-1:0] w_rr_n;

  // Scan offsets from the pointer; the k/i double loop keeps every index constant.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_rr_n  = r_rr;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && bus.req_i[k] && (k == (int'(r_rr) + i) % NREQ)) begin
          w_found   = 1'b1;
          w_pick[k] = 1'b1;
          w_rr_n    = RRW'((k + 1) % NREQ);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_grant) begin
      r_rr <= w_rr_n;
    end
  end
`else
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req_i[k]) begin
        w_found   = 1'b1;
        w_pick[k] = 1'b1;
      end
    end
  end
`endif

  // Eligibility looks only at the registered count; same-cycle releases land next cycle.
  assign w_grant  = (r_state == S_RUN) && !bus.drain_i && (r_free != '0) && w_found;
  assign w_free_n = r_free - {{(WID-1){1'b0}}, w_grant} + w_nrel;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_RUN:   if (bus.drain_i) w_state_n = S_DRAIN;
      S_DRAIN: if (w_free_n == MAX) w_state_n = S_DONE;
      S_DONE:  if (!bus.drain_i) w_state_n = S_RUN;
      default: w_state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_free  <= MAX;
      r_gnt   <= '0;
      r_state <= S_RUN;
      r_err   <= 1'b0;
      for (int k = 0; k < NREQ; k++) r_own[k] <= '0;
    end else begin
      r_free  <= w_free_n;
      r_gnt   <= w_grant ? w_pick : '0;
      r_state <= w_state_n;
      r_err   <= r_err | w_bad_rel;
      for (int k = 0; k < NREQ; k++) begin
        r_own[k] <= r_own[k] + WID'(w_grant && w_pick[k]) - WID'(w_rel_ok[k]);
      end
    end
  end

  assign bus.gnt_o   = r_gnt;
  assign bus.free_o  = r_free;
  assign bus.full_o  = (r_free == MAX);
  assign bus.empty_o = (r_free == '0);
  assign bus.idle_o  = (r_state == S_DONE);
  assign bus.err_o   = r_err;
endmodule

// File: tb/tb_token_pool_arb.sv
// tb/tb_token_pool_arb.sv - self-checking bench for token_pool_arb with a behavioural pool model
module tb_token_pool_arb;
  localparam int NREQ = 4;
  localparam int WID  = 2;
  localparam int MAX  = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  int              m_free;
  int              m_own [NREQ];
  int              m_rr;
  int              m_mode;   // 0 = granting, 1 = draining, 2 = drained
  logic            m_err;
  logic [NREQ-1:0] m_gnt;
  logic            cur_drain;

  token_pool_arb_if #(.NREQ(NREQ), .WID(WID)) bus ();
  token_pool_arb #(.NREQ(NREQ), .WID(WID)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_free = MAX;
    for (int k = 0; k < NREQ; k++) m_own[k] = 0;
    m_rr = 0; m_mode = 0; m_err = 1'b0; m_gnt = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] req, input logic [NREQ-1:0] rel, input logic drain);
    int win;
    int idx;
    win = -1;
    if (m_mode == 0 && !drain && m_free > 0) begin
      for (int i = 0; i < NREQ; i++) begin
`ifdef TOKEN_RR_EN
        idx = (m_rr + i) % NREQ;
`else
        idx = i;
`endif
        if (win < 0 && req[idx]) win = idx;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (rel[k]) begin
        if (m_own[k] > 0) begin m_own[k]--; m_free++; end
        else m_err = 1'b1;
      end
    end
    m_gnt = '0;
    if (win >= 0) begin
      m_gnt[win] = 1'b1; m_free--; m_own[win]++; m_rr = (win + 1) % NREQ;
    end
    if (m_mode == 0) begin
      if (drain) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_free == MAX) m_mode = 2;
    end else if (!drain) begin
      m_mode = 0;
    end
  endtask

  task automatic tick(input logic [NREQ-1:0] req, input logic [NREQ-1:0] rel, input logic drain);
    bus.req_i = req; bus.rel_i = rel; bus.drain_i = drain; cur_drain = drain;
    model_step(req, rel, drain);
    @(posedge clk); #1;
  endtask

  task automatic release_all();
    for (int k = 0; k < NREQ; k++) begin
      while (m_own[k] > 0) tick('0, NREQ'(1 << k), 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req_i = '0; bus.rel_i = '0; bus.drain_i = 1'b0; cur_drain = 1'b0;
    model_reset();
    @(posedge clk); #1;
    if (bus.free_o !== 2'd3) begin n_fail++; $display("FAIL reset_free: got %0d expected 3", bus.free_o); end n_checks++;
    if (bus.full_o !== 1'b1) begin n_fail++; $display("FAIL reset_full: got %b expected 1", bus.full_o); end n_checks++;
    if (bus.empty_o !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %b expected 0", bus.empty_o); end n_checks++;
    if (bus.idle_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b expected 0", bus.idle_o); end n_checks++;
    if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end n_checks++;
    if (bus.gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt_o); end n_checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_exhaust();
    logic [NREQ-1:0] exp_g;
    int exp_f;
    for (int c = 0; c < 5; c++) begin
      tick(4'b0001, '0, 1'b0);
      exp_g = (c < 3) ? 4'b0001 : 4'b0000;
      exp_f = (c < 3) ? 2 - c : 0;
      if (bus.gnt_o !== exp_g) begin n_fail++; $display("FAIL exhaust_gnt c%0d: got %b expected %b", c, bus.gnt_o, exp_g); end n_checks++;
      if (int'(bus.free_o) != exp_f) begin n_fail++; $display("FAIL exhaust_free c%0d: got %0d expected %0d", c, bus.free_o, exp_f); end n_checks++;
    end
    if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL exhaust_empty: got %b expected 1", bus.empty_o); end n_checks++;
    for (int c = 0; c < 3; c++) begin
      tick('0, 4'b0001, 1'b0);
      if (int'(bus.free_o) != c + 1) begin n_fail++; $display("FAIL exhaust_rel_free c%0d: got %0d expected %0d", c, bus.free_o, c + 1); end n_checks++;
    end
    if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL exhaust_own3: err got %b expected 0", bus.err_o); end n_checks++;
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_seq [5];
`ifdef TOKEN_RR_EN
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int c = 0; c < 5; c++) begin
      tick(4'b1111, m_gnt, 1'b0);
      if (bus.gnt_o !== exp_seq[c]) begin n_fail++; $display("FAIL contention_gnt c%0d: got %b expected %b", c, bus.gnt_o, exp_seq[c]); end n_checks++;
      if (int'(bus.free_o) != m_free) begin n_fail++; $display("FAIL contention_free c%0d: got %0d expected %0d", c, bus.free_o, m_free); end n_checks++;
    end
    tick('0, m_gnt, 1'b0);
    if (bus.free_o !== 2'd3) begin n_fail++; $display("FAIL contention_end_free: got %0d expected 3", bus.free_o); end n_checks++;
  endtask

  task automatic test_simul();
    for (int c = 0; c < 3; c++) tick(4'b0010, '0, 1'b0);
    if (bus.free_o !== 2'd0) begin n_fail++; $display("FAIL simul_setup_free: got %0d expected 0", bus.free_o); end n_checks++;
    tick(4'b0100, 4'b0010, 1'b0);
    if (bus.gnt_o !== 4'b0000) begin n_fail++; $display("FAIL simul_nogrant: got %b expected 0000", bus.gnt_o); end n_checks++;
    if (bus.free_o !== 2'd1) begin n_fail++; $display("FAIL simul_rel_free: got %0d expected 1", bus.free_o); end n_checks++;
    tick(4'b0100, '0, 1'b0);
    if (bus.gnt_o !== 4'b0100) begin n_fail++; $display("FAIL simul_late_gnt: got %b expected 0100", bus.gnt_o); end n_checks++;
    tick('0, 4'b0110, 1'b0);
    tick('0, 4'b0010, 1'b0);
    tick(4'b0001, '0, 1'b0);
    tick(4'b0001, '0, 1'b0);
    tick(4'b0001, 4'b0001, 1'b0);
    if (bus.gnt_o !== 4'b0001) begin n_fail++; $display("FAIL simul_same_gnt: got %b expected 0001", bus.gnt_o); end n_checks++;
    if (bus.free_o !== 2'd1) begin n_fail++; $display("FAIL simul_same_free: got %0d expected 1", bus.free_o); end n_checks++;
    tick('0, 4'b0001, 1'b0);
    tick('0, 4'b0001, 1'b0);
    if (bus.free_o !== 2'd3) begin n_fail++; $display("FAIL simul_end_free: got %0d expected 3", bus.free_o); end n_checks++;
    if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL simul_end_err: got %b expected 0", bus.err_o); end n_checks++;
  endtask

  task automatic test_illegal();
    tick('0, 4'b1000, 1'b0);
    if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", bus.err_o); end n_checks++;
    if (bus.free_o !== 2'd3) begin n_fail++; $display("FAIL illegal_free: got %0d expected 3", bus.free_o); end n_checks++;
    for (int c = 0; c < 3; c++) begin
      tick('0, '0, 1'b0);
      if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky c%0d: got %b expected 1", c, bus.err_o); end n_checks++;
    end
  endtask

  task automatic test_drain();
    int k1;
    tick(4'b0011, '0, 1'b0);
    tick(4'b0011, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick(4'b1111, '0, 1'b1);
      if (bus.gnt_o !== 4'b0000) begin n_fail++; $display("FAIL drain_nogrant c%0d: got %b expected 0000", c, bus.gnt_o); end n_checks++;
      if (bus.idle_o !== 1'b0) begin n_fail++; $display("FAIL drain_idle_early c%0d: got %b expected 0", c, bus.idle_o); end n_checks++;
    end
    for (int r = 0; r < 2; r++) begin
      k1 = 0;
      while (m_own[k1] == 0 && k1 < NREQ - 1) k1++;
      tick(4'b1111, NREQ'(1 << k1), 1'b1);
      if (bus.idle_o !== (r == 1)) begin n_fail++; $display("FAIL drain_idle_rel%0d: got %b expected %b", r, bus.idle_o, (r == 1)); end n_checks++;
    end
    tick(4'b1111, '0, 1'b1);
    if (bus.idle_o !== 1'b1) begin n_fail++; $display("FAIL drain_idle_hold: got %b expected 1", bus.idle_o); end n_checks++;
    tick(4'b1111, '0, 1'b0);
    if (bus.idle_o !== 1'b0) begin n_fail++; $display("FAIL drain_resume_idle: got %b expected 0", bus.idle_o); end n_checks++;
    tick(4'b1111, '0, 1'b0);
    if (bus.gnt_o === 4'b0000 || bus.gnt_o !== m_gnt) begin n_fail++; $display("FAIL drain_resume_gnt: got %b expected %b", bus.gnt_o, m_gnt); end n_checks++;
    release_all();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] req, rel;
    logic drn;
    drn = 1'b0;
    for (int c = 0; c < 300; c++) begin
      req = NREQ'($urandom);
      rel = '0;
      for (int k = 0; k < NREQ; k++) if (m_own[k] > 0 && $urandom_range(0, 2) == 0) rel[k] = 1'b1;
      if ($urandom_range(0, 30) == 0) rel[$urandom_range(0, NREQ - 1)] = 1'b1;
      if ($urandom_range(0, 19) == 0) drn = ~drn;
      tick(req, rel, drn);
      if (bus.gnt_o !== m_gnt || int'(bus.free_o) != m_free || bus.full_o !== (m_free == MAX) ||
          bus.empty_o !== (m_free == 0) || bus.idle_o !== (m_mode == 2) || bus.err_o !== m_err) begin
        n_fail++;
        $display("FAIL random c%0d: got gnt=%b free=%0d full=%b empty=%b idle=%b err=%b expected gnt=%b free=%0d idle=%b err=%b",
                 c, bus.gnt_o, bus.free_o, bus.full_o, bus.empty_o, bus.idle_o, bus.err_o, m_gnt, m_free, (m_mode == 2), m_err);
      end
      n_checks++;
    end
    release_all();
    tick('0, '0, 1'b0);
    tick('0, '0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) tick(4'b1111, '0, 1'b0);
    if (int'(bus.free_o) != m_free || m_free != 0) begin n_fail++; $display("FAIL areset_setup_free: got %0d expected 0", bus.free_o); end n_checks++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.free_o !== 2'd3) begin n_fail++; $display("FAIL areset_free: got %0d expected 3", bus.free_o); end n_checks++;
    if (bus.gnt_o !== 4'b0000) begin n_fail++; $display("FAIL areset_gnt: got %b expected 0000", bus.gnt_o); end n_checks++;
    if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL areset_err: got %b expected 0", bus.err_o); end n_checks++;
    if (bus.idle_o !== 1'b0) begin n_fail++; $display("FAIL areset_idle: got %b expected 0", bus.idle_o); end n_checks++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_exhaust();
    test_contention();
    test_simul();
    test_illegal();
    test_drain();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/token_pool_arb.md
# token_pool_arb

Shared token-pool controller. It arbitrates `NREQ` requesters for a pool of `2^WID-1` tokens. The pool is tracked by an up/down free counter: each grant decrements it and each release increments it. The block also tracks outstanding tokens per requester and supports a drain sequence that blocks new grants until every token is back. It sits between client agents and any resource sized as a saturating `WID`-bit counter.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WID`, 4: counter width. `MAX = 2^WID-1` tokens.

- `clk_i`  in  1  clock; all state updates on posedge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  NREQ  per-requester token request, level.
- `rel_i`  in  NREQ  per-requester token release, one token per asserted bit per cycle.
- `drain_i`  in  1  drain request, level.
- `gnt_o`  out  NREQ  one-hot grant pulse, registered.
- `free_o`  out  WID  free tokens (`free_q`).
- `full_o`  out  1  `free_q == MAX`.
- `empty_o`  out  1  `free_q == 0`.
- `idle_o`  out  1  FSM in `DONE`.
- `err_o`  out  1  sticky illegal-release flag.

## Operation
- **State:**
  - `free_q[WID]`
  - `own_q[NREQ][WID]`, outstanding tokens per requester
  - `rr_q`, round-robin pointer
  - `gnt_q`
  - FSM `state_q`
  - `err_q`
- **Reset values:** `free_q=MAX`, `own_q=0`, `gnt_o=0`, `rr_q=0`, `state=RUN`, `err_o=0`. Outputs at reset are therefore `full_o=1`, `empty_o=0`, `idle_o=0`, `free_o=MAX`.
- **Grant eligibility:** a grant is issued only if `state==RUN` and `free_q!=0`. Same-cycle releases do not count toward `free_q` for eligibility. At most one grant per cycle.
- **Winner selection:** round-robin starting at index `rr_q`. After a grant to requester `k`, `rr_q` becomes `(k+1) mod NREQ`.
- **Release validity:** `rel_i[k]` is valid iff `own_q[k]!=0`. An invalid release is ignored (no counter change) and sets `err_q` until reset.
- **Counter updates:**
  - `free_n = free_q - g + popcount(valid releases)`, where `g` = grant issued this cycle.
  - `own_n[k] = own_q[k] + (gnt to k) - (valid rel k)`.
  - A grant and a release on the same requester in the same cycle leave `own` unchanged.
- **Width rule:** the invariant `free_q + sum(own_q) == MAX` always holds, so no wrap-around is possible. The bench asserts no wrap.
- **FSM:**
  - `RUN`: go to `DRAIN` when `drain_i=1`. The grant decision in that same cycle is suppressed.
  - `DRAIN`: no grants; releases are still accepted. Go to `DONE` when `free_n==MAX`.
  - `DONE`: `idle_o=1`. Go to `RUN` when `drain_i=0`. While `drain_i` stays high, remain in `DONE`.
  - `drain_i` deasserted while in `DRAIN`: the block still completes the drain to `DONE`, then returns to `RUN` on the next cycle.
- **Reset mid-operation:** all grants and ownership are discarded and the pool reverts to `MAX` immediately (asynchronous). Clients must treat tokens as lost.

## Timing
- **Grant latency:** `req_i` sampled at edge `t` → `gnt_o` high during cycle `t+1` for exactly one cycle. `free_o` reflects the decrement in the same cycle `gnt_o` is high.
- **Holding requests:** a requester holding `req_i` receives further grants in later cycles, subject to arbitration and availability. Requesters drop `req_i` on seeing `gnt_o` if they need only one token.
- **Release latency:** release at edge `t` → `free_o` increments in cycle `t+1`.
- **Drain:**
  - `drain_i` sampled at edge `t` → no `gnt_o` in cycle `t+1`.
  - `idle_o` rises in the cycle after the last valid release that brings `free` to `MAX`.
  - If the pool is already full, `idle_o` rises at `t+2` (`RUN`→`DRAIN`→`DONE`).
- **`full_o`, `empty_o`:** combinational from `free_q`, so they carry no extra latency.

## Configuration
- **`TOKEN_RR_EN` defined:** round-robin arbitration as described above, with the `rr_q` pointer.
- **`TOKEN_RR_EN` undefined:** fixed priority, lowest index wins. `rr_q` is not instantiated.
- The FSM, counters and error behaviour are identical in both builds.

## Test plan
All scenarios use `NREQ=4`, `WID=2` (`MAX=3`).
- **Reset, then request with nothing free:** reset, then `req_i=4'b0001` held until exhaustion → grants at three consecutive cycles, `free_o` 3→2→1→0, `empty_o=1`, no fourth grant, `own[0]=3`.
- **Contention:** `req_i=4'b1111` held, release each grant one cycle later → with `TOKEN_RR_EN`, grants rotate 0,1,2,3,0. Without it, requester 0 always wins.
- **Simultaneous grant and release:**
  - `free=0`, requester 1 releases while requester 2 requests → no grant that cycle, `free_o=1` next cycle, grant to 2 one cycle after.
  - `free=1`, grant to 0 and release by 0 in the same cycle → `free` stays 1, `own[0]` unchanged.
- **Illegal release:** `rel_i=4'b1000` with `own[3]=0` → `err_o` rises next cycle and stays high, `free_o` unchanged.
- **Drain:** 2 tokens outstanding, then `drain_i=1` with `req_i` active → no grants; `idle_o=1` one cycle after the second release. Deassert `drain_i` → `RUN`, grants resume.
- **Mid-operation reset:** assert `rst_ni=0` asynchronously with `free=0` → `free_o=3`, `gnt_o=0`, `err_o=0`, `idle_o=0` immediately, without waiting for a clock edge.
